// File: rtl/cpu_timing_gen_pkg.sv
// Shared encodings for the machine-cycle / beat generator.
// Holds the FSM state enum, the one-hot beat constants and the default timeout.
package cpu_timing_gen_pkg;

    typedef enum logic [1:0] {
        TG_IDLE  = 2'd0,
        TG_IF    = 2'd1,
        TG_EX    = 2'd2,
        TG_FAULT = 2'd3
    } tg_state_e;

    localparam logic [3:0] BEAT_NONE = 4'b0000;
    localparam logic [3:0] BEAT_T1   = 4'b0001;
    localparam logic [3:0] BEAT_T2   = 4'b0010;
    localparam logic [3:0] BEAT_T3   = 4'b0100;
    localparam logic [3:0] BEAT_T4   = 4'b1000;

    localparam int TG_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cpu_timing_gen_if.sv
// Control/status bundle between the timing generator and its environment.
// The environment (master) drives sequencing inputs; the generator (slave) drives flags, beats and status.
interface cpu_timing_gen_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             output_done;
    logic             Mif;
    logic             Mex;
    logic             T1;
    logic             T2;
    logic             T3;
    logic             T4;
    logic             busy;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] retired;

    modport master (
        output start, halt_req, output_done,
        input  Mif, Mex, T1, T2, T3, T4, busy, halted, timeout_err, retired
    );

    modport slave (
        input  start, halt_req, output_done,
        output Mif, Mex, T1, T2, T3, T4, busy, halted, timeout_err, retired
    );

endinterface

// File: rtl/tg_beat_ring.sv
// Four-beat one-hot ring: restart at T1, advance one beat per clock and park on T4.
// Clearing to zero has priority over restart so IDLE/FAULT always show no beat.
module tg_beat_ring
    import cpu_timing_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr_t1,
    input  logic       i_clr_zero,
    input  logic       i_adv,
    output logic [3:0] o_beat
);

    logic [3:0] r_beat;

    always_ff @(posedge clk) begin
        if (rst || i_clr_zero) begin
            r_beat <= BEAT_NONE;
        end else if (i_clr_t1) begin
            r_beat <= BEAT_T1;
        end else if (i_adv && (r_beat != BEAT_T4)) begin
            r_beat <= r_beat << 1;
        end
    end

    assign o_beat = r_beat;

endmodule

// File: rtl/cpu_timing_gen.sv
// Machine-cycle (IF/EX) and beat (T1..T4) generator with halt sequencing,
// retired-instruction counting and a sticky bus-stall timeout fault.
module cpu_timing_gen
    import cpu_timing_gen_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TG_TIMEOUT_DEFAULT,
    parameter int WAIT_W         = 8,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    cpu_timing_gen_if.slave  bus
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    tg_state_e         r_state;
    tg_state_e         w_next_state;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic [CNT_W-1:0]  r_retired;
    logic              w_retire;
    logic              w_clr_t1;
    logic              w_clr_zero;
    logic              w_adv;
    logic [3:0]        w_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= TG_IDLE;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Completion beats timeout; wait never wraps because FAULT is taken at WAIT_LAST.
    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait;
        w_retire     = 1'b0;
        w_clr_t1     = 1'b0;
        w_clr_zero   = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            TG_IDLE: begin
                if (bus.start) begin
                    w_next_state = TG_IF;
                    w_clr_t1     = 1'b1;
                    w_wait_next  = '0;
                end
            end
            TG_IF, TG_EX: begin
                if (bus.output_done) begin
                    w_wait_next = '0;
                    if (r_state == TG_IF) begin
                        w_next_state = TG_EX;
                        w_clr_t1     = 1'b1;
                    end else begin
                        w_retire = 1'b1;
                        if (bus.halt_req) begin
                            w_next_state = TG_IDLE;
                            w_clr_zero   = 1'b1;
                        end else begin
                            w_next_state = TG_IF;
                            w_clr_t1     = 1'b1;
                        end
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_next_state = TG_FAULT;
                    w_clr_zero   = 1'b1;
                end else begin
                    w_adv       = 1'b1;
                    w_wait_next = r_wait + WAIT_W'(1);
                end
            end
            TG_FAULT: begin
                w_clr_zero = 1'b1;
            end
            default: begin
                w_next_state = TG_IDLE;
                w_clr_zero   = 1'b1;
            end
        endcase
    end

    tg_beat_ring u_beat_ring (
        .clk        (clk),
        .rst        (rst),
        .i_clr_t1   (w_clr_t1),
        .i_clr_zero (w_clr_zero),
        .i_adv      (w_adv),
        .o_beat     (w_beat)
    );

    assign bus.Mif         = (r_state == TG_IF);
    assign bus.Mex         = (r_state == TG_EX);
    assign bus.T1          = w_beat[0];
    assign bus.T2          = w_beat[1];
    assign bus.T3          = w_beat[2];
    assign bus.T4          = w_beat[3];
    assign bus.busy        = (r_state == TG_IF) || (r_state == TG_EX);
    assign bus.halted      = (r_state == TG_IDLE);
    assign bus.timeout_err = (r_state == TG_FAULT);
    assign bus.retired     = r_retired;

endmodule

// File: tb/tb_cpu_timing_gen.sv
// Directed bench: instance A uses the default timeout, instance B a timeout of 8;
// both share the same inputs and each scenario checks the instance it targets.
module tb_cpu_timing_gen;
    import cpu_timing_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic haltReq = 1'b0;
    logic done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_timing_gen_if #(.CNT_W(32)) ifA ();
    cpu_timing_gen_if #(.CNT_W(32)) ifB ();

    assign ifA.start = start;
    assign ifA.halt_req = haltReq;
    assign ifA.output_done = done;
    assign ifB.start = start;
    assign ifB.halt_req = haltReq;
    assign ifB.output_done = done;

    cpu_timing_gen #(.TIMEOUT_CYCLES(255), .WAIT_W(8), .CNT_W(32)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA.slave)
    );

    cpu_timing_gen #(.TIMEOUT_CYCLES(8), .WAIT_W(8), .CNT_W(32)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB.slave)
    );

    // Packed view: {Mif, Mex, T4, T3, T2, T1, busy, halted, timeout_err}
    logic [8:0] outA;
    logic [8:0] outB;
    assign outA = {ifA.Mif, ifA.Mex, ifA.T4, ifA.T3, ifA.T2, ifA.T1, ifA.busy, ifA.halted, ifA.timeout_err};
    assign outB = {ifB.Mif, ifB.Mex, ifB.T4, ifB.T3, ifB.T2, ifB.T1, ifB.busy, ifB.halted, ifB.timeout_err};

    function automatic logic [8:0] expOut(input tg_state_e s, input logic [3:0] beat);
        logic inIf;
        logic inEx;
        inIf = (s == TG_IF);
        inEx = (s == TG_EX);
        return {inIf, inEx, beat, inIf | inEx, s == TG_IDLE, s == TG_FAULT};
    endfunction

    task automatic applyStimulus(input logic iRst, input logic iStart, input logic iHalt, input logic iDone);
        rst = iRst;
        start = iStart;
        haltReq = iHalt;
        done = iDone;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset then idle
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("resetA", 32'(outA), 32'(expOut(TG_IDLE, BEAT_NONE)));
        checkOutput("resetB", 32'(outB), 32'(expOut(TG_IDLE, BEAT_NONE)));
        checkOutput("resetRetA", ifA.retired, 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("idleA", 32'(outA), 32'(expOut(TG_IDLE, BEAT_NONE)));
            checkOutput("idleRetA", ifA.retired, 32'd0);
        end

        // ALU instruction: IF/T1, IF/T2, EX/T1, IF/T1
        applyStimulus(0, 1, 0, 0);
        checkOutput("aluIfT1", 32'(outA), 32'(expOut(TG_IF, BEAT_T1)));
        applyStimulus(0, 0, 0, 0);
        checkOutput("aluIfT2", 32'(outA), 32'(expOut(TG_IF, BEAT_T2)));
        applyStimulus(0, 1, 0, 1);
        checkOutput("aluExT1", 32'(outA), 32'(expOut(TG_EX, BEAT_T1)));
        applyStimulus(0, 0, 0, 1);
        checkOutput("aluNextIfT1", 32'(outA), 32'(expOut(TG_IF, BEAT_T1)));
        checkOutput("aluRetired", ifA.retired, 32'd1);

        // Long memory wait: cycle 1 is IF/T1, T4 from cycle 4 to 20
        for (int c = 2; c <= 20; c++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("longWaitIf", 32'(outA),
                32'(expOut(TG_IF, (c == 2) ? BEAT_T2 : (c == 3) ? BEAT_T3 : BEAT_T4)));
        end
        checkOutput("longWaitFaultB", 32'(outB), 32'(expOut(TG_FAULT, BEAT_NONE)));
        applyStimulus(0, 0, 0, 1);
        checkOutput("longWaitExT1", 32'(outA), 32'(expOut(TG_EX, BEAT_T1)));

        // Halt at instruction boundary; halt_req ignored during IF
        applyStimulus(0, 0, 0, 1);
        checkOutput("haltPreIfT1", 32'(outA), 32'(expOut(TG_IF, BEAT_T1)));
        checkOutput("haltPreRet", ifA.retired, 32'd2);
        applyStimulus(0, 0, 1, 0);
        checkOutput("haltIgnoredIf", 32'(outA), 32'(expOut(TG_IF, BEAT_T2)));
        applyStimulus(0, 0, 1, 1);
        checkOutput("haltExT1", 32'(outA), 32'(expOut(TG_EX, BEAT_T1)));
        applyStimulus(0, 0, 1, 1);
        checkOutput("haltIdle", 32'(outA), 32'(expOut(TG_IDLE, BEAT_NONE)));
        checkOutput("haltRetired", ifA.retired, 32'd3);
        applyStimulus(0, 0, 1, 1);
        checkOutput("idleIgnoresDone", 32'(outA), 32'(expOut(TG_IDLE, BEAT_NONE)));
        checkOutput("idleRetHeld", ifA.retired, 32'd3);

        // Timeout fault on B: FAULT 8 cycles after EX entry
        applyStimulus(1, 0, 0, 0);
        checkOutput("rstFaultB", 32'(outB), 32'(expOut(TG_IDLE, BEAT_NONE)));
        checkOutput("rstRetA", ifA.retired, 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("toIfT1", 32'(outB), 32'(expOut(TG_IF, BEAT_T1)));
        applyStimulus(0, 0, 0, 1);
        checkOutput("toExT1", 32'(outB), 32'(expOut(TG_EX, BEAT_T1)));
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("toExWait", 32'(outB),
                32'(expOut(TG_EX, (k == 1) ? BEAT_T2 : (k == 2) ? BEAT_T3 : BEAT_T4)));
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("toFault", 32'(outB), 32'(expOut(TG_FAULT, BEAT_NONE)));
        checkOutput("toNoFaultA", 32'(outA), 32'(expOut(TG_EX, BEAT_T4)));
        applyStimulus(0, 1, 0, 0);
        checkOutput("faultIgnStart", 32'(outB), 32'(expOut(TG_FAULT, BEAT_NONE)));
        applyStimulus(0, 0, 0, 1);
        checkOutput("faultIgnDone", 32'(outB), 32'(expOut(TG_FAULT, BEAT_NONE)));
        checkOutput("faultRetired", ifB.retired, 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("faultRstIdle", 32'(outB), 32'(expOut(TG_IDLE, BEAT_NONE)));

        // Done exactly at wait = 7 on B: normal transition
        applyStimulus(0, 1, 0, 0);
        checkOutput("edgeIfT1", 32'(outB), 32'(expOut(TG_IF, BEAT_T1)));
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("edgeIfT4", 32'(outB), 32'(expOut(TG_IF, BEAT_T4)));
        applyStimulus(0, 0, 0, 1);
        checkOutput("edgeExT1", 32'(outB), 32'(expOut(TG_EX, BEAT_T1)));

        // Reset mid-EX after one retirement
        applyStimulus(0, 0, 0, 1);
        checkOutput("midIfT1", 32'(outB), 32'(expOut(TG_IF, BEAT_T1)));
        checkOutput("midRet", ifB.retired, 32'd1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("midExT3", 32'(outB), 32'(expOut(TG_EX, BEAT_T3)));
        applyStimulus(1, 0, 0, 0);
        checkOutput("midRstIdle", 32'(outB), 32'(expOut(TG_IDLE, BEAT_NONE)));
        checkOutput("midRstRet", ifB.retired, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("postRstIdle", 32'(outB), 32'(expOut(TG_IDLE, BEAT_NONE)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_timing_gen.md
Name: cpu_timing_gen

Overview:
- Machine-cycle and beat generator that sits directly upstream of the CPU control decoder.
- Produces the machine-cycle flags Mif (fetch) and Mex (execute) and the one-hot beats T1..T4.
- Consumes the decoder's combinational output_done to finish each machine cycle.
- Also handles start/halt sequencing, counts retired instructions, and traps stalled bus transactions with a timeout fault.

Parameters:
- TIMEOUT_CYCLES, 255, clocks a machine cycle may last without output_done before faulting; must be < 2^WAIT_W.
- WAIT_W, 8, width of the per-machine-cycle wait counter.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching; ignored outside IDLE.
- halt_req  input  1  request stop after the current instruction completes.
- output_done  input  1  current machine cycle complete (from control decoder).
- Mif  output  1  fetch machine cycle active.
- Mex  output  1  execute machine cycle active.
- T1  output  1  beat 1.
- T2  output  1  beat 2.
- T3  output  1  beat 3.
- T4  output  1  beat 4.
- busy  output  1  high in IF or EX.
- halted  output  1  high in IDLE.
- timeout_err  output  1  sticky; high in FAULT.
- retired  output  CNT_W  count of completed EX cycles, wraps modulo 2^CNT_W.

Behaviour:
- Reset: state = IDLE, beat = none, wait = 0, retired = 0. All outputs 0 except halted = 1.
- States: IDLE, IF, EX, FAULT. Outputs are registered-state decodes:
  - Mif = (state == IF); Mex = (state == EX).
  - T1..T4 are all 0 in IDLE and FAULT.
  - In IF/EX exactly one of T1..T4 is high.
- IDLE: on start, go to IF with beat T1 and wait = 0.
- Beat progression within IF/EX, no output_done at the clock edge:
  - T1 -> T2 -> T3 -> T4, one per clock.
  - T4 holds while waiting.
  - wait increments each clock.
- output_done sampled high at an edge in IF: go to EX, T1, wait = 0.
- output_done sampled high at an edge in EX:
  - retired += 1.
  - If halt_req is high at the same edge, go to IDLE; otherwise go to IF, T1, wait = 0.
- Minimum machine-cycle length is one clock (done during T1 gives back-to-back T1 beats in the next machine cycle).
- Timeout:
  - If wait == TIMEOUT_CYCLES-1 at an edge with output_done low, go to FAULT.
  - FAULT is absorbing: timeout_err = 1 and beats cleared until rst.
- Simultaneous events:
  - output_done beats timeout on the same edge.
  - halt_req only acts at an EX completion; it is ignored during IF and in IDLE.
  - start is ignored when not in IDLE.
  - rst overrides everything, including mid-transaction, and returns to IDLE with retired cleared.
- wait saturates structurally, because FAULT is entered before it can wrap.
- No combinational path from output_done or any other input to any output.

Decomposition:
- Shared package/include holds:
  - state encodings TG_IDLE, TG_IF, TG_EX, TG_FAULT (2-bit);
  - beat one-hot constants BEAT_T1..BEAT_T4 (4-bit);
  - the default TIMEOUT_CYCLES.
- One natural sub-module: tg_beat_ring, a 4-bit one-hot shift register with clear-to-T1, hold-at-T4 and clear-to-zero controls.
- The FSM, wait counter and retired counter stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, release with start = 0 for 10 cycles.
  - Response: halted = 1, Mif = Mex = 0, T1..T4 = 0, retired = 0 throughout.
- ALU instruction sequence:
  - Stimulus: start pulse; output_done high during IF T2; output_done high during EX T1.
  - Response, cycle by cycle: IF/T1, IF/T2, EX/T1, IF/T1; retired = 1.
- Long memory wait:
  - Stimulus: in IF, output_done withheld 20 cycles, then asserted.
  - Response: T4 held from cycle 4 to cycle 20, then EX/T1 next cycle; timeout_err = 0.
- Halt at boundary:
  - Stimulus: halt_req held high during IF, with output_done at EX T1.
  - Response: IF completes normally; after EX done, state = IDLE, halted = 1, retired incremented by 1.
- Timeout fault (TIMEOUT_CYCLES = 8):
  - Stimulus: in EX, output_done never asserted.
  - Response: FAULT 8 cycles after EX entry; timeout_err = 1, beats = 0; start ignored; rst clears it.
- Done at timeout edge and reset mid-operation:
  - Stimulus: output_done exactly at wait = 7 with TIMEOUT_CYCLES = 8.
  - Response: normal transition, no fault.
  - Stimulus: rst asserted during EX/T3.
  - Response: IDLE next cycle, retired = 0.
